uart_rx_irq: RTL

//   Serial 8N1 UART receiver with RX FIFO. Drives the core's UART_INT external-interrupt input.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_rx_irq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receiver slice: the
//               receive FSM state type, the data width and the FIFO count
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module      : uart_sync_fifo
// Description : Synchronous FIFO with first-word-fall-through read. Pointers
//               carry one extra wrap bit so full and empty are told apart
//               without a separate counter. A push into a full FIFO is
//               accepted when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  // Head is forced to zero while empty so the output never shows stale data.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; wrap-around is plain modulo arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_irq.sv
// ============================================================================
// Module      : uart_rx_irq
// Description : 8N1 UART receiver with RX FIFO, sticky error flags and a
//               registered level interrupt for the core's UART_INT input.
//               Optional macro UART_RX_TIMEOUT_EN adds a character-timeout
//               flag; without it TIMEOUT is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_irq
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 434,
  parameter int FIFO_DEPTH    = 16,
  parameter int IRQ_THRESH    = 1,
  parameter int TIMEOUT_BITS  = 32
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic                               RXD,
  input  logic                               RD_EN,
  input  logic                               CLR_ERR,
  output logic [UART_DATA_W-1:0]             RD_DATA,
  output logic                               RX_EMPTY,
  output logic [cnt_width(FIFO_DEPTH)-1:0]   RX_COUNT,
  output logic                               OVERRUN,
  output logic                               FRAME_ERR,
  output logic                               TIMEOUT,
  output logic                               UART_INT
);

  localparam int CW     = cnt_width(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BAUD);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BAUD - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_W - 1);

  // Parameter sanity checks at elaboration.
  if (CLKS_PER_BAUD < 4) begin : g_bad_baud
    $error("CLKS_PER_BAUD must be >= 4");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if ((IRQ_THRESH < 1) || (IRQ_THRESH > FIFO_DEPTH)) begin : g_bad_thresh
    $error("IRQ_THRESH must be in 1..FIFO_DEPTH");
  end
  if (TIMEOUT_BITS < 1) begin : g_bad_timeout
    $error("TIMEOUT_BITS must be >= 1");
  end

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_prev;
  rx_state_t              r_state;
  logic [BAUD_W-1:0]      r_baud_cnt;
  logic [2:0]             r_bit_idx;
  logic [UART_DATA_W-1:0] r_shreg;
  logic                   r_push;
  logic                   r_overrun;
  logic                   r_frame_err;
  logic                   r_int;

  logic                   w_fall;
  logic                   w_mid_stop;
  logic                   w_fe_set;
  logic                   w_ovr_set;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_cnt_hit;
  logic                   w_timeout;

  assign w_fall     = r_prev & ~r_sync2;
  assign w_mid_stop = (r_state == STOP) && (r_baud_cnt == BAUD_LAST);
  assign w_fe_set   = w_mid_stop & ~r_sync2;
  // A stored byte arriving at a full FIFO is lost unless a pop frees a slot.
  assign w_ovr_set  = r_push & w_full & ~RD_EN;
  assign w_cnt_hit  = (RX_COUNT >= CW'(IRQ_THRESH));

  // Two-flop synchroniser plus previous-sample register for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receive FSM: start-bit qualification, mid-bit data sampling, stop check.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_push     <= 1'b0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        IDLE: begin
          // Only a fresh falling edge starts a frame, so a held-low break
          // line cannot retrigger reception.
          if (w_fall) begin
            r_baud_cnt <= '0;
            r_state    <= START;
          end
        end
        START: begin
          if (r_baud_cnt == BAUD_HALF) begin
            if (r_sync2) begin
              r_state <= IDLE;
            end else begin
              r_baud_cnt <= '0;
              r_bit_idx  <= '0;
              r_state    <= DATA;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            r_shreg    <= {r_sync2, r_shreg[UART_DATA_W-1:1]};
            if (r_bit_idx == LAST_BIT) r_state <= STOP;
            else                       r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            r_push     <= r_sync2;
            r_state    <= IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_push  (r_push),
    .i_pop   (RD_EN),
    .i_wdata (r_shreg),
    .o_rdata (RD_DATA),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (RX_COUNT)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_BITS + 1);

  logic [BAUD_W-1:0] r_to_baud;
  logic [TO_W-1:0]   r_to_bits;
  logic              r_timeout;
  logic              w_pop_done;
  logic              w_push_done;
  logic              w_start_det;
  logic              w_to_tick;
  logic              w_to_fire;

  assign w_pop_done  = RD_EN & ~w_empty;
  assign w_push_done = r_push & (~w_full | w_pop_done);
  assign w_start_det = (r_state == IDLE) & w_fall;
  assign w_to_tick   = (r_state == IDLE) & ~w_empty & (r_to_baud == BAUD_LAST);
  // Fires once, on the bit period that reaches the limit; the bit counter
  // then saturates so a cleared flag is not immediately re-raised.
  assign w_to_fire   = w_to_tick & (r_to_bits == TO_W'(TIMEOUT_BITS - 1));
  assign w_timeout   = r_timeout;

  // Idle bit-period counter and sticky timeout flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_to_baud <= '0;
      r_to_bits <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_push_done | w_pop_done | w_start_det) begin
        r_to_baud <= '0;
        r_to_bits <= '0;
      end else if ((r_state == IDLE) && !w_empty) begin
        if (r_to_baud == BAUD_LAST) begin
          r_to_baud <= '0;
          if (r_to_bits != TO_W'(TIMEOUT_BITS)) r_to_bits <= r_to_bits + 1'b1;
        end else begin
          r_to_baud <= r_to_baud + 1'b1;
        end
      end
      r_timeout <= w_to_fire | (r_timeout & ~(CLR_ERR | RD_EN));
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign TIMEOUT   = w_timeout;
  assign OVERRUN   = r_overrun;
  assign FRAME_ERR = r_frame_err;
  assign UART_INT  = r_int;
  assign RX_EMPTY  = w_empty;

  // Sticky error flags (set wins over clear) and the registered interrupt.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      r_overrun   <= w_ovr_set | (r_overrun & ~CLR_ERR);
      r_frame_err <= w_fe_set | (r_frame_err & ~CLR_ERR);
      r_int       <= w_cnt_hit | r_overrun | r_frame_err | w_timeout;
    end
  end

endmodule

`default_nettype wire
